// File: rtl/bin_search_guesser.sv
// Binary-search guesser: narrows [lo,hi] on lt/gt/eq feedback until eq.
// Optional stalled-responder watchdog: define BIN_SEARCH_TIMEOUT_EN.
module bin_search_guesser (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       cmp_valid,
    input  logic       cmp_lt,
    input  logic       cmp_gt,
    input  logic       cmp_eq,
    output logic [3:0] guess,
    output logic       guess_valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] found,
    output logic       err,
    output logic [2:0] step_cnt
);

    typedef enum logic [1:0] {IDLE, ASK, DONE, ERR} state_t;

    state_t     state, state_nx;
    logic [4:0] lo, hi, lo_nx, hi_nx;
    logic [4:0] g5;
    logic [3:0] found_nx;
    logic [2:0] step_nx;
    logic       done_nx, err_nx;
    logic       accept, one_hot, wd_trip;

    assign guess       = 4'((lo + hi) >> 1);
    assign g5          = {1'b0, guess};
    assign guess_valid = (state == ASK);
    assign busy        = guess_valid;
    assign accept      = guess_valid & cmp_valid;
    assign one_hot     = ({cmp_lt, cmp_gt, cmp_eq} == 3'b100)
                       | ({cmp_lt, cmp_gt, cmp_eq} == 3'b010)
                       | ({cmp_lt, cmp_gt, cmp_eq} == 3'b001);

`ifdef BIN_SEARCH_TIMEOUT_EN
    logic [3:0] wd;

    // Fifteenth consecutive idle ASK cycle aborts the search
    assign wd_trip = guess_valid && !cmp_valid && (wd == 4'd14);

    always_ff @(posedge clk) begin
        if (rst || !guess_valid || cmp_valid)
            wd <= 4'd0;
        else
            wd <= wd + 4'd1;
    end
`else
    assign wd_trip = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        lo_nx    = lo;
        hi_nx    = hi;
        found_nx = found;
        step_nx  = step_cnt;
        done_nx  = done;
        err_nx   = err;
        unique case (state)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_nx = ASK;
                    lo_nx    = 5'd0;
                    hi_nx    = 5'd15;
                    found_nx = 4'd0;
                    step_nx  = 3'd0;
                    done_nx  = 1'b0;
                    err_nx   = 1'b0;
                end
            end
            ASK: begin
                if (accept) begin
                    step_nx = step_cnt + 3'd1;
                    if (!one_hot) begin
                        state_nx = ERR;
                        err_nx   = 1'b1;
                    end else if (cmp_eq) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                        found_nx = guess;
                    end else if (cmp_lt) begin
                        // Bounds would cross: feedback contradicts earlier answers
                        if (g5 == hi) begin
                            state_nx = ERR;
                            err_nx   = 1'b1;
                        end else begin
                            lo_nx = g5 + 5'd1;
                        end
                    end else begin
                        if (g5 == lo) begin
                            state_nx = ERR;
                            err_nx   = 1'b1;
                        end else begin
                            hi_nx = g5 - 5'd1;
                        end
                    end
                end else if (wd_trip) begin
                    state_nx = ERR;
                    err_nx   = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lo       <= 5'd0;
            hi       <= 5'd15;
            found    <= 4'd0;
            step_cnt <= 3'd0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_nx;
            lo       <= lo_nx;
            hi       <= hi_nx;
            found    <= found_nx;
            step_cnt <= step_nx;
            done     <= done_nx;
            err      <= err_nx;
        end
    end

endmodule

// File: doc/bin_search_guesser.md
BIN_SEARCH_GUESSER -- requirements
Module: bin_search_guesser

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single rising-edge clock.
REQ-002 SHALL have port rst, input, 1 bit, a synchronous active-high reset sampled on the rising edge of clk.
REQ-003 SHALL have port start, input, 1 bit, requesting a new search.
REQ-004 SHALL have port cmp_valid, input, 1 bit, meaning the responder's compare result is present this cycle.
REQ-005 SHALL have ports cmp_lt, cmp_gt and cmp_eq, input, 1 bit each, giving the compare result where A = guess and B = the secret.
REQ-006 SHALL have port guess, output, 4 bits, the current candidate value.
REQ-007 SHALL have port guess_valid, output, 1 bit, asserted when guess is awaiting a compare result.
REQ-008 SHALL have port busy, output, 1 bit, asserted while a search is in progress.
REQ-009 SHALL have port done, output, 1 bit, a level meaning the secret was found.
REQ-010 SHALL have port found, output, 4 bits, the located value; it is valid while done = 1.
REQ-011 SHALL have port err, output, 1 bit, a level meaning the search was aborted.
REQ-012 SHALL have port step_cnt, output, 3 bits, the number of compare results consumed in the current or last search.

Function
REQ-013 SHALL implement the FSM states IDLE, ASK, DONE and ERR.
REQ-014 SHALL keep internal 5-bit bounds lo and hi; start loads lo = 0 and hi = 15.
REQ-015 SHALL drive guess = (lo + hi) >> 1, truncated to 4 bits.
REQ-016 SHALL leave IDLE, DONE or ERR for ASK when start = 1, clearing step_cnt, done, err and found in the same edge.
REQ-017 SHALL ignore start while in ASK.
REQ-018 SHALL assert guess_valid = busy = 1 only in ASK.
REQ-019 SHALL sample cmp_* only on an edge where guess_valid = 1 and cmp_valid = 1; at that edge step_cnt increments by 1.
REQ-020 SHALL ignore cmp_valid outside ASK.
REQ-021 SHALL, on a valid result with exactly cmp_eq set, enter DONE with found = guess and done = 1.
REQ-022 SHALL, on a valid result with exactly cmp_lt set (guess < secret), set lo = guess + 1 and stay in ASK.
REQ-023 SHALL, on a valid result with exactly cmp_gt set, set hi = guess - 1 and stay in ASK.
REQ-024 SHALL present the new guess in the cycle following the accepted result; one result is consumed per cycle while cmp_valid is held.
REQ-025 SHALL enter ERR with err = 1 when a valid result does not have exactly one of lt/gt/eq set.
REQ-026 SHALL enter ERR when cmp_lt is received with guess == hi, or cmp_gt with guess == lo (inconsistent feedback, bounds would cross); lo and hi SHALL NOT wrap.
REQ-027 SHALL guarantee that any consistent responder ends in DONE after at most 5 results.
REQ-028 SHALL hold done, found, err and step_cnt stable in DONE and ERR until the next start or rst.

Reset
REQ-029 SHALL, on rst = 1 at a clock edge, force state = IDLE, lo = 0, hi = 15, guess = 7, guess_valid = busy = done = err = 0, found = 0 and step_cnt = 0.
REQ-030 SHALL give rst priority over start and cmp_valid, including mid-search; the aborted search leaves no residue.

Configuration
REQ-031 SHALL, with macro BIN_SEARCH_TIMEOUT_EN defined, include a 4-bit watchdog that clears on entry to ASK and on each accepted result, counts each ASK cycle without cmp_valid, and enters ERR when it reaches 15.
REQ-032 SHALL, with BIN_SEARCH_TIMEOUT_EN undefined, have no watchdog; ASK waits indefinitely and ports are identical.

Verification
REQ-033 SHALL pass: responder with secret = 15 answering every cycle -> guesses 7, 11, 13, 14, 15; done = 1, found = 15, step_cnt = 5.
REQ-034 SHALL pass: secret = 0 -> guesses 7, 3, 1, 0; done, found = 0, step_cnt = 4; secret = 7 -> done after 1 result.
REQ-035 SHALL pass: cmp_lt = cmp_gt = 1 with cmp_valid at the first guess -> err = 1, done = 0, step_cnt = 1, guess_valid = 0.
REQ-036 SHALL pass: answer gt to guesses 7, 3, 1, 0 -> at guess 0, enter ERR.
REQ-037 SHALL pass: rst asserted after 2 results -> next cycle all outputs at reset values; start -> guess = 7 again.
REQ-038 SHALL pass: with BIN_SEARCH_TIMEOUT_EN defined, start then no cmp_valid for 15 cycles -> err = 1; without the macro -> still in ASK after 100 cycles.
